// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared card/hand constants and dealer state encoding
// Purpose: common types for the 24-game datapath dealer.
// Ports: none (package).
package game_pkg;

  localparam int CARD_W = 4;
  localparam int HAND_N = 4;
  localparam int HAND_W = CARD_W * HAND_N;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    SAMPLE
  } state_t;

  // Extract card slot i (0 = first accepted card) from a packed hand.
  function automatic logic [CARD_W-1:0] slot_of(input logic [HAND_W-1:0] hand,
                                                input logic [1:0]        i);
    return hand[{i, 2'b00} +: CARD_W];
  endfunction

endpackage

// File: rtl/card_filter.sv
// rtl/card_filter.sv - combinational legality check for one drawn card
// Purpose: accept a value iff it lies in 1..MAX_VAL and, when UNIQUE is set,
//          does not repeat any card already placed in slots 0..idx-1.
// Ports:
//   value  in  4   candidate card from the generator
//   hand   in  16  cards accepted so far in this deal
//   idx    in  2   number of slots already filled
//   accept out 1   value may be stored in slot idx
module card_filter
  import game_pkg::*;
#(
  parameter int MAX_VAL = 13,
  parameter int UNIQUE  = 0
) (
  input  logic [CARD_W-1:0] value,
  input  logic [HAND_W-1:0] hand,
  input  logic [1:0]        idx,
  output logic              accept
);

  logic w_in_range;
  logic w_dup;

  assign w_in_range = (value != '0) && (value <= 4'(MAX_VAL));

  // Only slots below idx hold cards from this deal; higher slots are zero.
  always_comb begin
    w_dup = 1'b0;
    for (int i = 0; i < HAND_N; i++) begin
      if ((UNIQUE != 0) && (2'(i) < idx) && (slot_of(hand, 2'(i)) == value)) begin
        w_dup = 1'b1;
      end
    end
  end

  assign accept = w_in_range && !w_dup;

endmodule

// File: rtl/hand_dealer.sv
// rtl/hand_dealer.sv - deal sequencer that draws four legal cards from the LFSR
// Purpose: on deal_req, step the external generator SKIP times per draw,
//          judge each sample, and pack four accepted cards into a hand.
//          Aborts with err after MAX_DRAWS attempts.
// Ports:
//   clk        in  1   system clock
//   rst        in  1   synchronous active-high reset
//   deal_req   in  1   start a deal (honoured only when idle)
//   rand_in    in  4   registered generator output
//   rand_en    out 1   generator step enable
//   busy       out 1   deal in progress
//   hand       out 16  packed cards, slot 0 in [3:0]
//   hand_valid out 1   complete hand available
//   err        out 1   last deal aborted at MAX_DRAWS
module hand_dealer
  import game_pkg::*;
#(
  parameter int MAX_VAL   = 13,
  parameter int SKIP      = 1,
  parameter int MAX_DRAWS = 32,
  parameter int UNIQUE    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              deal_req,
  input  logic [CARD_W-1:0] rand_in,
  output logic              rand_en,
  output logic              busy,
  output logic [HAND_W-1:0] hand,
  output logic              hand_valid,
  output logic              err
);

  localparam int DRAW_W = $clog2(MAX_DRAWS + 1);
  localparam int STEP_W = (SKIP > 1) ? $clog2(SKIP) : 1;

  state_t              r_state;
  logic                r_rand_en;
  logic                r_busy;
  logic [HAND_W-1:0]   r_hand;
  logic                r_hand_valid;
  logic                r_err;
  logic [1:0]          r_idx;
  logic                r_done;
  logic [DRAW_W-1:0]   r_draw_cnt;
  logic [STEP_W-1:0]   r_step_cnt;

  logic                w_accept;
  logic                w_take;
  logic [DRAW_W-1:0]   w_draw_next;
  logic                w_max_reached;
  logic                w_last_step;

  card_filter #(
    .MAX_VAL (MAX_VAL),
    .UNIQUE  (UNIQUE)
  ) u_card_filter (
    .value  (rand_in),
    .hand   (r_hand),
    .idx    (r_idx),
    .accept (w_accept)
  );

  assign w_take        = w_accept && !r_done;
  assign w_draw_next   = r_draw_cnt + DRAW_W'(1);
  assign w_max_reached = (w_draw_next == DRAW_W'(MAX_DRAWS));
  assign w_last_step   = (r_step_cnt == STEP_W'(SKIP - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_rand_en    <= 1'b0;
      r_busy       <= 1'b0;
      r_hand       <= '0;
      r_hand_valid <= 1'b0;
      r_err        <= 1'b0;
      r_idx        <= 2'd0;
      r_done       <= 1'b0;
      r_draw_cnt   <= '0;
      r_step_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (deal_req) begin
            r_hand       <= '0;
            r_hand_valid <= 1'b0;
            r_err        <= 1'b0;
            r_idx        <= 2'd0;
            r_done       <= 1'b0;
            r_draw_cnt   <= '0;
            r_step_cnt   <= '0;
            r_state      <= STEP;
            r_rand_en    <= 1'b1;
            r_busy       <= 1'b1;
          end
        end

        STEP: begin
          if (w_last_step) begin
            r_state   <= SAMPLE;
            r_rand_en <= 1'b0;
          end else begin
            r_step_cnt <= r_step_cnt + STEP_W'(1);
          end
        end

        SAMPLE: begin
          r_draw_cnt <= w_draw_next;
          r_step_cnt <= '0;
          if (w_take) begin
            r_hand[{r_idx, 2'b00} +: CARD_W] <= rand_in;
            // Slot 3 filled: latch done instead of letting idx wrap.
            if (r_idx == 2'd3) begin
              r_done <= 1'b1;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
          // A completing accept wins over the draw limit on the same draw.
          if (w_take && (r_idx == 2'd3)) begin
            r_hand_valid <= 1'b1;
            r_state      <= IDLE;
            r_busy       <= 1'b0;
          end else if (w_max_reached) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state   <= STEP;
            r_rand_en <= 1'b1;
          end
        end

        default: begin
          r_state   <= IDLE;
          r_rand_en <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  // Gate with rst so the generator is not stepped on the reset edge.
  assign rand_en    = r_rand_en & ~rst;
  assign busy       = r_busy;
  assign hand       = r_hand;
  assign hand_valid = r_hand_valid;
  assign err        = r_err;

endmodule

// File: tb/tb_hand_dealer.sv
// tb/tb_hand_dealer.sv - directed self-checking bench for hand_dealer
module tb_hand_dealer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  rst;
  logic [3:0]  deal_req;
  logic [3:0]  rand_en;
  logic [3:0]  busy;
  logic [3:0]  hand_valid;
  logic [3:0]  err;
  logic [15:0] hand     [4];
  logic [3:0]  rand_in  [4];
  logic [3:0]  lfsr     [4];
  logic [3:0]  load_en;
  logic [3:0]  load_val [4];

  logic        stub_en;
  logic [2:0]  stub_ptr = 3'd0;
  logic [3:0]  stub_val = 4'd0;

  int checks   = 0;
  int failures = 0;

  hand_dealer u_def (
    .clk(clk), .rst(rst[0]), .deal_req(deal_req[0]), .rand_in(rand_in[0]),
    .rand_en(rand_en[0]), .busy(busy[0]), .hand(hand[0]),
    .hand_valid(hand_valid[0]), .err(err[0])
  );

  hand_dealer #(.MAX_VAL(2), .MAX_DRAWS(3)) u_small (
    .clk(clk), .rst(rst[1]), .deal_req(deal_req[1]), .rand_in(rand_in[1]),
    .rand_en(rand_en[1]), .busy(busy[1]), .hand(hand[1]),
    .hand_valid(hand_valid[1]), .err(err[1])
  );

  hand_dealer #(.UNIQUE(1)) u_uniq (
    .clk(clk), .rst(rst[2]), .deal_req(deal_req[2]), .rand_in(rand_in[2]),
    .rand_en(rand_en[2]), .busy(busy[2]), .hand(hand[2]),
    .hand_valid(hand_valid[2]), .err(err[2])
  );

  hand_dealer #(.SKIP(2)) u_skip (
    .clk(clk), .rst(rst[3]), .deal_req(deal_req[3]), .rand_in(rand_in[3]),
    .rand_en(rand_en[3]), .busy(busy[3]), .hand(hand[3]),
    .hand_valid(hand_valid[3]), .err(err[3])
  );

  // 4-bit XNOR LFSR: 0,1,3,7,14,13,11,6,12,9,2,5,10,4,8,0,...
  function automatic logic [3:0] lfsr_next(input logic [3:0] q);
    return {q[2:0], ~(q[3] ^ q[2])};
  endfunction

  function automatic logic [3:0] stub_at(input logic [2:0] p);
    case (p)
      3'd0:    return 4'd3;
      3'd1:    return 4'd3;
      3'd2:    return 4'd5;
      3'd3:    return 4'd6;
      default: return 4'd7;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (load_en[i])      lfsr[i] <= load_val[i];
      else if (rand_en[i]) lfsr[i] <= lfsr_next(lfsr[i]);
    end
  end

  always @(posedge clk) begin
    if (stub_en && rand_en[2]) begin
      stub_val <= stub_at(stub_ptr);
      stub_ptr <= stub_ptr + 3'd1;
    end
  end

  assign rand_in[0] = lfsr[0];
  assign rand_in[1] = lfsr[1];
  assign rand_in[2] = stub_en ? stub_val : lfsr[2];
  assign rand_in[3] = lfsr[3];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_lfsr(input int i, input logic [3:0] v);
    @(negedge clk);
    load_en[i]  = 1'b1;
    load_val[i] = v;
    @(posedge clk);
    #1 load_en[i] = 1'b0;
  endtask

  // Issue one request and watch cycles 1..bound (cycle 1 follows edge 0).
  task automatic run_deal(input int i, input int bound, input bit noise,
                          output int done_cyc, output int busy_cnt, output int en_cnt,
                          output logic [15:0] hand_c1, output logic flag_c1);
    done_cyc = -1;
    busy_cnt = 0;
    en_cnt   = 0;
    hand_c1  = 16'hxxxx;
    flag_c1  = 1'bx;
    @(negedge clk);
    deal_req[i] = 1'b1;
    @(posedge clk);
    #1 deal_req[i] = 1'b0;
    for (int c = 1; c <= bound; c++) begin
      @(negedge clk);
      if (c == 1) begin
        hand_c1 = hand[i];
        flag_c1 = hand_valid[i] | err[i];
      end
      if (hand_valid[i] | err[i]) begin
        done_cyc = c;
        break;
      end
      if (busy[i])    busy_cnt++;
      if (rand_en[i]) en_cnt++;
      if (noise) deal_req[i] = (c == 3) || (c == 5);
    end
    deal_req[i] = 1'b0;
  endtask

  int          done_cyc, busy_cnt, en_cnt;
  logic [15:0] hand_c1;
  logic        flag_c1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 4'hF;
    deal_req = 4'h0;
    stub_en  = 1'b0;
    load_en  = 4'hF;
    load_val[0] = 4'd0;
    load_val[1] = 4'd0;
    load_val[2] = 4'd9;
    load_val[3] = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    load_en = 4'h0;
    rst     = 4'h0;
    #1;
    check_val("rst_rand_en",    32'(rand_en[0]),    32'd0);
    check_val("rst_busy",       32'(busy[0]),       32'd0);
    check_val("rst_hand",       32'(hand[0]),       32'h0);
    check_val("rst_hand_valid", 32'(hand_valid[0]), 32'd0);
    check_val("rst_err",        32'(err[0]),        32'd0);

    // Reset mid-deal: rst raised for cycle 5 (STEP of draw 3).
    @(negedge clk);
    deal_req[0] = 1'b1;
    @(posedge clk);
    #1 deal_req[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst[0] = 1'b1;
    @(negedge clk);
    check_val("midrst_en_low", 32'(rand_en[0]), 32'd0);
    @(posedge clk);
    #1 rst[0] = 1'b0;
    #1;
    check_val("midrst_busy",  32'(busy[0]),       32'd0);
    check_val("midrst_en",    32'(rand_en[0]),    32'd0);
    check_val("midrst_hand",  32'(hand[0]),       32'h0);
    check_val("midrst_hv",    32'(hand_valid[0]), 32'd0);
    check_val("midrst_err",   32'(err[0]),        32'd0);
    check_val("midrst_lfsr",  32'(lfsr[0]),       32'd3);

    // Defaults from 0000: 1,3,7,14(rej),13.
    load_lfsr(0, 4'd0);
    run_deal(0, 40, 1'b0, done_cyc, busy_cnt, en_cnt, hand_c1, flag_c1);
    check_val("a_hand",     32'(hand[0]),       32'hD731);
    check_val("a_done_cyc", 32'(done_cyc),      32'd11);
    check_val("a_busy_cnt", 32'(busy_cnt),      32'd10);
    check_val("a_hv",       32'(hand_valid[0]), 32'd1);
    check_val("a_err",      32'(err[0]),        32'd0);
    check_val("a_busy_end", 32'(busy[0]),       32'd0);

    // Back-to-back deal with ignored requests while busy: 11,6,12,9.
    run_deal(0, 40, 1'b1, done_cyc, busy_cnt, en_cnt, hand_c1, flag_c1);
    check_val("b_hand_c1",  32'(hand_c1),  32'h0);
    check_val("b_flag_c1",  32'(flag_c1),  32'd0);
    check_val("b_hand",     32'(hand[0]),  32'h9C6B);
    check_val("b_done_cyc", 32'(done_cyc), 32'd9);
    check_val("b_busy_cnt", 32'(busy_cnt), 32'd8);

    // MAX_VAL=2, MAX_DRAWS=3: 1,3,7 then abort.
    run_deal(1, 40, 1'b0, done_cyc, busy_cnt, en_cnt, hand_c1, flag_c1);
    check_val("c_done_cyc", 32'(done_cyc),      32'd7);
    check_val("c_err",      32'(err[1]),        32'd1);
    check_val("c_hv",       32'(hand_valid[1]), 32'd0);
    check_val("c_hand",     32'(hand[1]),       32'h0001);

    // UNIQUE=1 from 1001: 2,5,10,4.
    run_deal(2, 40, 1'b0, done_cyc, busy_cnt, en_cnt, hand_c1, flag_c1);
    check_val("d_hand",     32'(hand[2]),  32'h4A52);
    check_val("d_done_cyc", 32'(done_cyc), 32'd9);

    // Stubbed source 3,3,5,6,7: second 3 is a duplicate.
    stub_en = 1'b1;
    run_deal(2, 40, 1'b0, done_cyc, busy_cnt, en_cnt, hand_c1, flag_c1);
    check_val("d_dup_hand",     32'(hand[2]),       32'h7653);
    check_val("d_dup_done_cyc", 32'(done_cyc),      32'd11);
    check_val("d_dup_hv",       32'(hand_valid[2]), 32'd1);

    // SKIP=2 from 0000: samples 3,14(rej),11,12,2.
    run_deal(3, 60, 1'b0, done_cyc, busy_cnt, en_cnt, hand_c1, flag_c1);
    check_val("e_hand",     32'(hand[3]),  32'h2CB3);
    check_val("e_done_cyc", 32'(done_cyc), 32'd16);
    check_val("e_busy_cnt", 32'(busy_cnt), 32'd15);
    check_val("e_en_cnt",   32'(en_cnt),   32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
